// File: rtl/seq_alu.sv
// seq_alu: 3-bit-opcode ALU, valid/ready in, one-cycle out_valid pulse; 1-cycle latency, WIDTH cycles for DIV/REM.
// SEQ_ALU_DIV_EN builds the restoring divider (in_ready low while dividing); without it DIV/REM return 0.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic [WIDTH:0]   out,
  output logic             out_valid,
  output logic             div_by_zero
);
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MAG = 3'd7;

  logic [WIDTH:0] out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           dbz_q, dbz_d;
  logic           accept;
  logic           is_div_op;
  logic           b_zero;
  logic [WIDTH:0] a_ext, b_ext, alu_res;

  assign accept    = in_valid && in_ready;
  assign is_div_op = (select == OP_DIV) || (select == OP_REM);
  assign b_zero    = (b == '0);
  assign a_ext     = {1'b0, a};
  assign b_ext     = {1'b0, b};

  // Single-cycle results; for DIV/REM this is only the divide-by-zero answer.
  always_comb begin
    alu_res = '0;
    case (select)
      OP_NOP: alu_res = a_ext;
      OP_ADD: alu_res = a_ext + b_ext;
      OP_SUB: alu_res = a_ext - b_ext;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: alu_res = {1'b0, {WIDTH{1'b1}}};
      OP_REM: alu_res = a_ext;
`else
      OP_DIV: alu_res = '0;
      OP_REM: alu_res = '0;
`endif
      OP_SHL: alu_res = {a, 1'b0};
      OP_SHR: alu_res = {2'b00, a[WIDTH-1:1]};
      OP_MAG: alu_res = {{WIDTH{1'b0}}, (a > b)};
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_DIVIDE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic             fits;

  assign in_ready = (state_q == ST_IDLE);
  assign rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign quo_sh   = {quo_q[WIDTH-2:0], 1'b0};
  assign fits     = (rem_sh >= {1'b0, dvs_q});

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    is_rem_d    = is_rem_q;
    out_d       = out_q;
    dbz_d       = dbz_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div_op && !b_zero) begin
            rem_d    = '0;
            quo_d    = a;
            dvs_d    = b;
            cnt_d    = CW'(WIDTH);
            is_rem_d = (select == OP_REM);
            state_d  = ST_DIVIDE;
          end else begin
            out_d       = alu_res;
            dbz_d       = is_div_op && b_zero;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        rem_d = fits ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_d = {quo_sh[WIDTH-1:1], fits};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d       = is_rem_q ? rem_d : {1'b0, quo_d};
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
    end
  end
`else
  assign in_ready = 1'b1;

  always_comb begin
    out_d       = out_q;
    dbz_d       = dbz_q;
    out_valid_d = 1'b0;
    if (accept) begin
      out_d       = alu_res;
      dbz_d       = is_div_op && b_zero;
      out_valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: WIDTH=4 instance for the main sequence, WIDTH=8 instance for the wide divide.
module tb_seq_alu;
  localparam int W = 4;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, div_by_zero;
  logic [W-1:0] a, b;
  logic [2:0]   select;
  logic [W:0]   out;

  logic       in_valid8, in_ready8, out_valid8, dbz8;
  logic [7:0] a8, b8;
  logic [2:0] sel8;
  logic [8:0] out8;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select), .out(out), .out_valid(out_valid),
    .div_by_zero(div_by_zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .select(sel8), .out(out8), .out_valid(out_valid8),
    .div_by_zero(dbz8)
  );

  typedef struct {
    logic [W:0] res;
    logic       dbz;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model: result, flag and the cycle count at which out_valid should be seen.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int base);
    exp_t e;
    int   ai, bi, r, lat;
    bit   dz;
    ai  = int'(av);
    bi  = int'(bv);
    r   = 0;
    lat = 0;
    dz  = ((op == 3'd3) || (op == 3'd4)) && (bi == 0);
    case (op)
      3'd0: r = ai;
      3'd1: r = ai + bi;
      3'd2: r = (ai - bi + (1 << (W + 1))) % (1 << (W + 1));
      3'd3: begin
        if (!DIV_EN) r = 0;
        else if (dz) r = (1 << W) - 1;
        else begin r = ai / bi; lat = W; end
      end
      3'd4: begin
        if (!DIV_EN) r = 0;
        else if (dz) r = ai;
        else begin r = ai % bi; lat = W; end
      end
      3'd5: r = ai * 2;
      3'd6: r = ai / 2;
      default: r = (ai > bi) ? 1 : 0;
    endcase
    e.res = r[W:0];
    e.dbz = dz;
    e.due = base + lat;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        check("out", 64'(out), 64'(e.res));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("latency_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    select   = op;
    a        = av;
    b        = bv;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("ready_timeout", 64'(in_ready), 64'(1));
    sb.push_back(model(op, av, bv, cyc + 1));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int k;
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; select = '0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_out", 64'(out), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_in_ready8", 64'(in_ready8), 64'(1));
    @(negedge clk) rst = 1'b0;

    // ADD carry and SUB borrow, back-to-back
    issue(3'd1, 4'd15, 4'd1);
    issue(3'd2, 4'd3, 4'd5);
    // shifts, compare, pass-through
    issue(3'd5, 4'b1001, 4'd0);
    issue(3'd6, 4'b1001, 4'd0);
    issue(3'd7, 4'd5, 4'd5);
    issue(3'd0, 4'd7, 4'd0);
    idle(2);

    // DIV with ADD held during the busy window
    issue(3'd3, 4'd13, 4'd4);
`ifdef SEQ_ALU_DIV_EN
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in_valid = 1'b1; select = 3'd1; a = 4'd2; b = 4'd6;
      check("busy_in_ready", 64'(in_ready), 64'(0));
    end
`else
    @(negedge clk);
    in_valid = 1'b0;
    check("nodiv_in_ready", 64'(in_ready), 64'(1));
`endif
    issue(3'd1, 4'd2, 4'd6);
    issue(3'd4, 4'd13, 4'd4);

    // divide by zero, then a normal op clears the flag
    issue(3'd3, 4'd9, 4'd0);
    issue(3'd4, 4'd9, 4'd0);
    issue(3'd1, 4'd1, 4'd1);

    // reset two steps into a divide
    issue(3'd3, 4'd15, 4'd2);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_out", 64'(out), 64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_dbz", 64'(div_by_zero), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    @(negedge clk) rst = 1'b0;
    idle(W + 2);
    issue(3'd3, 4'd15, 4'd2);

    for (int i = 0; i < 40; i++) begin : rnd
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      issue(rop, ra, rb);
    end
    idle(W + 4);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    // wide divide on the 8-bit instance
    @(negedge clk);
    in_valid8 = 1'b1; sel8 = 3'd3; a8 = 8'd255; b8 = 8'd1;
    check("w8_ready_before", 64'(in_ready8), 64'(1));
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    check("w8_ready_after", 64'(in_ready8), 64'(DIV_EN ? 0 : 1));
    k = 0;
    while (out_valid8 !== 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("w8_latency", 64'(k), 64'(DIV_EN ? 8 : 0));
    check("w8_out", 64'(out8), 64'(DIV_EN ? 255 : 0));
    check("w8_dbz", 64'(dbz8), 64'(0));
    @(posedge clk);
    #1;
    check("w8_pulse_len", 64'(out_valid8), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
